uart_packet_rx: RTL
===================

UART_PACKET_RX -- requirements
Module: uart_packet_rx

Interface
REQ-001 Parameter CLK_HZ SHALL default to 50000000 and give the clk50 frequency in Hz.
REQ-002 Parameter BAUD SHALL default to 115200 and give the serial bit rate.
REQ-003 Parameter PKT_BYTES SHALL default to 5 and give the bytes per packet, legal range 2..16.
REQ-004 Parameter TIMEOUT_BITS SHALL default to 20 and give the idle bit-times after which a partial packet is discarded.
REQ-005 clk50  input  1  sole clock, all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 rx_in  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-008 packet  output  8*PKT_BYTES  last accepted packet, first received byte in the most significant byte.
REQ-009 pkt_valid  output  1  one-cycle pulse when packet updates.
REQ-010 byte_cnt  output  4  bytes of the current partial packet accepted so far.
REQ-011 frame_err  output  1  one-cycle pulse on a low stop bit.
REQ-012 timeout_err  output  1  one-cycle pulse when a partial packet times out.
REQ-013 chk_err  output  1  one-cycle pulse on a checksum mismatch (see Configuration).

Function
REQ-014 rx_in SHALL pass through a 2-flop synchroniser before any use.
REQ-015 The oversample tick SHALL fire every DIV = floor(CLK_HZ/(16*BAUD)) cycles, giving 16 ticks per bit (27 at defaults); the tick divider SHALL be cleared on every entry to START.
REQ-016 The receive FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-017 IDLE SHALL move to START on a synchronised high-to-low transition.
REQ-018 START SHALL move to DATA at tick 8 if the line is low, else return to IDLE (glitch reject, no error).
REQ-019 DATA SHALL sample 8 bits, each at tick 8 of its bit, LSB first, then move to STOP.
REQ-020 STOP SHALL sample at tick 8 and return to IDLE: if high, the byte is accepted; if low, frame_err pulses, the byte is dropped and byte_cnt clears.
REQ-021 After a frame error, IDLE SHALL ignore the line until it has been sampled high once.
REQ-022 An accepted byte SHALL shift into an internal assembly register and increment byte_cnt.
REQ-023 When the accepted byte is number PKT_BYTES, in the cycle after the stop-bit sample, the block SHALL load packet with the full assembly, pulse pkt_valid and clear byte_cnt.
REQ-024 packet SHALL hold its value between pkt_valid pulses; partial data SHALL never appear on it.
REQ-025 The timeout counter SHALL count ticks only in IDLE with byte_cnt != 0, and SHALL clear on any START entry or when byte_cnt = 0.
REQ-026 When the timeout counter reaches TIMEOUT_BITS*16, the block SHALL pulse timeout_err, clear byte_cnt, discard the partial data and leave packet unchanged.
REQ-027 timeout_err, frame_err, pkt_valid and chk_err SHALL be mutually exclusive in any cycle; the timeout is frozen outside IDLE, so it cannot coincide with byte completion.
REQ-028 Back-to-back frames with no idle gap beyond the stop bit SHALL be received without loss.

Reset
REQ-029 While rst is high: FSM at IDLE; packet, byte_cnt, all pulses, the assembly register, the dividers and the timeout counter at 0; synchroniser flops at 1.
REQ-030 Reset asserted mid-frame or mid-packet SHALL discard all partial data, produce no error pulse, and start reception only on a new start edge after release.

Configuration
REQ-031 With UART_RX_CHECKSUM_EN defined, the last byte of each packet SHALL equal the XOR of the preceding PKT_BYTES-1 bytes; on a match, REQ-023 applies.
REQ-032 With UART_RX_CHECKSUM_EN defined and a mismatch, chk_err SHALL pulse instead of pkt_valid, packet SHALL be left unchanged and byte_cnt SHALL clear.
REQ-033 Without UART_RX_CHECKSUM_EN, no check SHALL be made and chk_err SHALL be tied to 0.

Verification (defaults, DIV = 27, macro undefined unless stated)
REQ-034 Send 0x11 0x22 0x33 0x44 0x55 -> one pkt_valid, packet = 0x1122334455, byte_cnt sequence 1,2,3,4,0.
REQ-035 Send 0xA5 with the stop bit low, then 0x01..0x05 -> frame_err once, then packet = 0x0102030405.
REQ-036 Send 0x01 0x02, idle 20 bit-times -> timeout_err at 320 ticks, byte_cnt = 0, packet unchanged; next 5 bytes assemble normally.
REQ-037 Drive a 4-tick low glitch -> no byte accepted, no error, byte_cnt = 0.
REQ-038 Assert rst after the third byte, then send 5 bytes -> only the new 5 bytes appear in packet.
REQ-039 With the macro defined, send 0x01 0x02 0x03 0x04 0x04 -> pkt_valid; send 0x01 0x02 0x03 0x04 0x05 -> chk_err, packet unchanged.

Source files
------------

// File: rtl/uart_packet_rx.sv
// uart_packet_rx: 8N1 serial receiver that assembles PKT_BYTES bytes into one
// packet, with frame-error, idle-timeout and (optional) checksum reporting.
// Optional feature: define UART_RX_CHECKSUM_EN to require the last byte of each
// packet to equal the XOR of the preceding bytes.
module uart_packet_rx #(
    parameter int CLK_HZ       = 50000000,
    parameter int BAUD         = 115200,
    parameter int PKT_BYTES    = 5,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                   clk50,
    input  logic                   rst,
    input  logic                   rx_in,
    output logic [8*PKT_BYTES-1:0] packet,
    output logic                   pkt_valid,
    output logic [3:0]             byte_cnt,
    output logic                   frame_err,
    output logic                   timeout_err,
    output logic                   chk_err
);
    localparam int DIV    = CLK_HZ / (16 * BAUD);
    localparam int DIV_W  = $clog2(DIV + 1);
    localparam int TO_LIM = TIMEOUT_BITS * 16;
    localparam int TO_W   = $clog2(TO_LIM + 1);
    localparam int AW     = 8 * PKT_BYTES;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q;
    logic              rx_s1_q, rx_s2_q, rx_prev_q;
    logic [1:0]        arm_q;       // marks when the synchroniser holds real line samples
    logic              wait_high_q; // line must be seen high before a new start edge
    logic [DIV_W-1:0]  div_q;
    logic [3:0]        tick_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
    logic [AW-1:0]     asm_q;
    logic [AW-1:0]     asm_d;
    logic [TO_W-1:0]   to_q;
    logic [3:0]        byte_cnt_q;
    logic [AW-1:0]     packet_q;
    logic              pkt_valid_q, frame_err_q, timeout_err_q;
    logic              tick;

    assign tick  = (div_q == DIV_W'(DIV - 1));
    assign asm_d = {asm_q[AW-9:0], shift_q};

`ifdef UART_RX_CHECKSUM_EN
    logic       chk_err_q;
    logic [7:0] xor_acc;

    // XOR of the bytes already held in the assembly register
    always_comb begin
        xor_acc = '0;
        for (int i = 0; i < PKT_BYTES - 1; i++) xor_acc = xor_acc ^ asm_q[8*i +: 8];
    end
    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

    // Receive FSM, byte/packet assembly, timeout and registered status pulses
    always_ff @(posedge clk50) begin
        if (rst) begin
            state_q       <= IDLE;
            rx_s1_q       <= 1'b1;
            rx_s2_q       <= 1'b1;
            rx_prev_q     <= 1'b1;
            arm_q         <= '0;
            wait_high_q   <= 1'b1;
            div_q         <= '0;
            tick_q        <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            asm_q         <= '0;
            to_q          <= '0;
            byte_cnt_q    <= '0;
            packet_q      <= '0;
            pkt_valid_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef UART_RX_CHECKSUM_EN
            chk_err_q     <= 1'b0;
`endif
        end else begin
            rx_s1_q       <= rx_in;
            rx_s2_q       <= rx_s1_q;
            rx_prev_q     <= rx_s2_q;
            arm_q         <= {arm_q[0], 1'b1};
            pkt_valid_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef UART_RX_CHECKSUM_EN
            chk_err_q     <= 1'b0;
`endif
            div_q <= tick ? '0 : div_q + DIV_W'(1);
            if (tick) tick_q <= tick_q + 4'd1;

            case (state_q)
                IDLE: begin
                    // Partial-packet timeout only runs while idle
                    if (byte_cnt_q == 4'd0) begin
                        to_q <= '0;
                    end else if (tick) begin
                        if (to_q == TO_W'(TO_LIM - 1)) begin
                            timeout_err_q <= 1'b1;
                            byte_cnt_q    <= '0;
                            asm_q         <= '0;
                            to_q          <= '0;
                        end else begin
                            to_q <= to_q + TO_W'(1);
                        end
                    end
                    if (wait_high_q) begin
                        if (arm_q[1] && rx_s2_q) wait_high_q <= 1'b0;
                    end else if (rx_prev_q && !rx_s2_q) begin
                        state_q <= START;
                        div_q   <= '0;
                        tick_q  <= '0;
                        to_q    <= '0;
                    end
                end
                START: begin
                    // Mid start bit: confirm low, else treat as a glitch
                    if (tick && tick_q == 4'd7) begin
                        tick_q  <= '0;
                        bit_q   <= '0;
                        state_q <= rx_s2_q ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (tick && tick_q == 4'd15) begin
                        shift_q <= {rx_s2_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= STOP;
                    end
                end
                STOP: begin
                    // Returning mid stop bit leaves time to catch a back-to-back start edge
                    if (tick && tick_q == 4'd15) begin
                        state_q <= IDLE;
                        if (!rx_s2_q) begin
                            frame_err_q <= 1'b1;
                            byte_cnt_q  <= '0;
                            asm_q       <= '0;
                            wait_high_q <= 1'b1;
                        end else if (byte_cnt_q == 4'(PKT_BYTES - 1)) begin
                            byte_cnt_q <= '0;
                            asm_q      <= '0;
`ifdef UART_RX_CHECKSUM_EN
                            if (shift_q == xor_acc) begin
                                packet_q    <= asm_d;
                                pkt_valid_q <= 1'b1;
                            end else begin
                                chk_err_q <= 1'b1;
                            end
`else
                            packet_q    <= asm_d;
                            pkt_valid_q <= 1'b1;
`endif
                        end else begin
                            asm_q      <= asm_d;
                            byte_cnt_q <= byte_cnt_q + 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign packet      = packet_q;
    assign pkt_valid   = pkt_valid_q;
    assign byte_cnt    = byte_cnt_q;
    assign frame_err   = frame_err_q;
    assign timeout_err = timeout_err_q;
endmodule
